pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it decides the write-enables, bubbles and flushes of the PC and pipeline registers, from load-use hazards, taken branches, jumps and data-memory wait states. It sits beside the main control decoder and drives the IF/ID, ID/EX, EX/MEM and MEM/WB register controls. A registered FSM bounds every memory wait with a timeout.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/hazard_sat_cnt.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// Holds the FSM state enum and the default widths/timeouts.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF  = 5;
  localparam int MEM_TIMEOUT_DEF = 8;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

endpackage

// File: rtl/hazard_sat_cnt.sv
// 16-bit saturating event counter with enable.
// Ports: clk, rst_n, en_i (count this cycle), cnt_o (holds at 0xFFFF).
module hazard_sat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: PC / pipe-register enables, bubbles,
// flushes from load-use, branch, jump and bounded data-memory waits.
// Inputs: ID regs/jmp, EX load/branch, MEM req/ack. Outputs: write
// enables, ifid_flush, idex_bubble, memwb_bubble, mem_err (registered).
// Option HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt (16-bit, sat).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_jmp,
  input  logic                  ex_memRead,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_bubble,
  output logic                  exmem_write,
  output logic                  memwb_bubble,
  output logic                  mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          freeze;
  logic          load_use;
  logic          sel_br, sel_lu, sel_jp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    freeze  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          freeze  = 1'b1;
          cnt_d   = CW'(1);
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          cnt_d   = '0;
          state_d = RUN;
        end else if (cnt_q < TMO) begin
          freeze = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end else begin
          // Timed out: drop the access and let the pipe move.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign load_use = ex_memRead && (ex_rt != '0) &&
                    ((ex_rt == id_rs) ||
                     (id_uses_rt && (ex_rt == id_rt)));

  // One-hot selects so the decoder arms are mutually exclusive.
  assign sel_br = !freeze && ex_branch_taken;
  assign sel_lu = !freeze && !ex_branch_taken && load_use;
  assign sel_jp = !freeze && !ex_branch_taken && !load_use && id_jmp;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
      end
      sel_br: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      sel_lu: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      sel_jp: begin
        ifid_flush = 1'b1;
      end
      default: begin
      end
    endcase
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_write   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  assign mem_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_sat_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (rst_n && !pc_write),
    .cnt_o (stall_cnt)
  );

  hazard_sat_cnt u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ifid_flush),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes expected
// output vectors, a negedge monitor pops and compares each cycle.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_jmp, ex_memRead;
  logic       ex_branch_taken, mem_req, mem_ack;
  logic       pc_write, ifid_write, ifid_flush, idex_write;
  logic       idex_bubble, exmem_write, memwb_bubble, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
  int          m_stall, m_flush;
`endif

  // {pc, ifid_w, flush, idex_w, bubble, exmem_w, memwb_bub, err}
  localparam logic [7:0] V_RST  = 8'b0000_0000;
  localparam logic [7:0] V_NORM = 8'b1101_0100;
  localparam logic [7:0] V_STL  = 8'b0001_1100;
  localparam logic [7:0] V_BR   = 8'b1111_1100;
  localparam logic [7:0] V_JMP  = 8'b1111_0100;
  localparam logic [7:0] V_FRZ  = 8'b0000_0010;
  localparam logic [7:0] V_ERR  = 8'b1101_0101;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .REG_ADDR_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_jmp          (id_jmp),
    .ex_memRead      (ex_memRead),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_bubble     (idex_bubble),
    .exmem_write     (exmem_write),
    .memwb_bubble    (memwb_bubble),
    .mem_err         (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always @(negedge clk) begin
    logic [7:0] e, a;
    string      n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pc_write, ifid_write, ifid_flush, idex_write,
           idex_bubble, exmem_write, memwb_bubble, mem_err};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %b want %b", n, a, e);
      end
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rt = 0; id_jmp = 0; ex_memRead = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic cyc(input logic [7:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
`ifdef HAZARD_PERF_CNT_EN
    if (!rst_n) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!e[7] && m_stall < 65535) m_stall++;
      if (e[5] && m_flush < 65535) m_flush++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef HAZARD_PERF_CNT_EN
    m_stall = 0;
    m_flush = 0;
`endif
    idle();
    rst_n = 1'b0;
    mem_req = 1'b1;
    ex_branch_taken = 1'b1;
    @(posedge clk);
    #1;
    cyc(V_RST, "reset_outs0");
    cyc(V_RST, "reset_outs1");
    idle();
    rst_n = 1'b1;
    cyc(V_NORM, "idle");

    ex_memRead = 1; ex_rt = 5; id_rs = 5;
    cyc(V_STL, "lu_rs");
    ex_rt = 0; id_rs = 0;
    cyc(V_NORM, "lu_r0");

    idle();
    ex_memRead = 1; ex_rt = 7; id_rt = 7; id_rs = 3;
    cyc(V_NORM, "lu_rt_unused");
    id_uses_rt = 1;
    cyc(V_STL, "lu_rt_used");

    ex_branch_taken = 1; id_jmp = 1; ex_rt = 3; id_rs = 3;
    cyc(V_BR, "br_prio");
    idle();
    id_jmp = 1;
    cyc(V_JMP, "jmp");
    ex_memRead = 1; ex_rt = 9; id_rs = 9;
    cyc(V_STL, "lu_over_jmp");

    idle();
    mem_req = 1;
    cyc(V_FRZ, "wait_c1");
    mem_req = 0; ex_branch_taken = 1; id_jmp = 1;
    cyc(V_FRZ, "wait_c2_frz");
    mem_ack = 1;
    cyc(V_BR, "wait_ack_rel");
    idle();
    cyc(V_NORM, "post_ack0");
    cyc(V_NORM, "post_ack1");

    mem_req = 1; mem_ack = 1;
    cyc(V_NORM, "ack_entry");
    idle();
    cyc(V_NORM, "ack_entry_run");

    mem_req = 1;
    cyc(V_FRZ, "tmo_c1");
    mem_req = 0;
    for (int i = 2; i <= 8; i++) cyc(V_FRZ, $sformatf("tmo_c%0d", i));
    cyc(V_NORM, "tmo_c9_rel");
    cyc(V_ERR, "tmo_c10_err");
    cyc(V_NORM, "tmo_c11");

    mem_req = 1;
    cyc(V_FRZ, "w2_c1");
    mem_req = 0;
    cyc(V_FRZ, "w2_c2");
    cyc(V_FRZ, "w2_c3");
    rst_n = 1'b0;
    cyc(V_RST, "w2_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(V_NORM, $sformatf("w2_run%0d", i));

    ex_memRead = 1; ex_rt = 4; id_rs = 4;
    cyc(V_STL, "lu_again");
    idle();
    id_jmp = 1;
    cyc(V_JMP, "jmp_again");
    idle();

`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 16'(m_stall)) begin
      failures++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, m_stall);
    end
    checks++;
    if (flush_cnt !== 16'(m_flush)) begin
      failures++;
      $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, m_flush);
    end
    ex_memRead = 1; ex_rt = 6; id_rs = 6;
    for (int i = 0; i < 70000; i++) cyc(V_STL, "sat_run");
    idle();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_sat: got %h want ffff", stall_cnt);
    end
`endif

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
